// File: rtl/entropy_collector.sv
// Bus initiator that samples the entropy generator's P/N words, XOR-mixes them,
// health-checks them for repetition and packs pairs into 32-bit words.
// Optional ENTROPY_COLLECTOR_RNG_CFG_EN adds two configuration writes before sampling starts.
module entropy_collector #(
    parameter int unsigned SAMPLE_DELAY = 8,
    parameter int unsigned REPEAT_MAX   = 4,
    parameter logic [7:0]  ADDR_P       = 8'h11,
    parameter logic [7:0]  ADDR_N       = 8'h12
`ifdef ENTROPY_COLLECTOR_RNG_CFG_EN
    ,
    parameter logic [7:0]  RNG1_VAL     = 8'h33,
    parameter logic [7:0]  RNG2_VAL     = 8'hcc
`endif
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    output logic        cs,
    output logic        we,
    output logic [7:0]  addr,
    output logic [15:0] dwrite,
    input  logic [15:0] dread,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        data_ack,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_P,
        RD_N,
        VALID,
        ERROR
`ifdef ENTROPY_COLLECTOR_RNG_CFG_EN
        ,
        CFG1,
        CFG2
`endif
    } state_t;

`ifdef ENTROPY_COLLECTOR_RNG_CFG_EN
    localparam state_t RUN_ENTRY = CFG1;
`else
    localparam state_t RUN_ENTRY = WAIT;
`endif

    state_t      state, next_state;
    logic [15:0] p_reg;
    logic [15:0] last_mix;
    logic [15:0] mix;
    logic [3:0]  rep_ctr;
    logic [7:0]  delay_ctr;
    logic        half;
    logic        first;
    logic        wait_done;
    logic        repeat_hit;
    logic        health_fail;

    assign mix         = p_reg ^ dread;
    assign wait_done   = (delay_ctr == 8'(SAMPLE_DELAY - 1));
    assign repeat_hit  = !first && (mix == last_mix);
    assign health_fail = repeat_hit && (rep_ctr == 4'(REPEAT_MAX - 2));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping enable abandons any partial sample; only VALID and ERROR ignore it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (enable) next_state = RUN_ENTRY;
            WAIT: begin
                if (!enable)        next_state = IDLE;
                else if (wait_done) next_state = RD_P;
            end
            RD_P:  next_state = enable ? RD_N : IDLE;
            RD_N: begin
                if (!enable)          next_state = IDLE;
                else if (health_fail) next_state = ERROR;
                else if (half)        next_state = VALID;
                else                  next_state = WAIT;
            end
            VALID: if (data_ack) next_state = enable ? WAIT : IDLE;
            ERROR: if (!enable) next_state = IDLE;
`ifdef ENTROPY_COLLECTOR_RNG_CFG_EN
            CFG1:  next_state = enable ? CFG2 : IDLE;
            CFG2:  next_state = enable ? WAIT : IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cs     = 1'b0;
        we     = 1'b0;
        addr   = 8'h00;
        dwrite = 16'h0000;
        case (state)
            RD_P: begin
                cs   = 1'b1;
                addr = ADDR_P;
            end
            RD_N: begin
                cs   = 1'b1;
                addr = ADDR_N;
            end
`ifdef ENTROPY_COLLECTOR_RNG_CFG_EN
            CFG1: begin
                cs     = 1'b1;
                we     = 1'b1;
                addr   = 8'h00;
                dwrite = {RNG1_VAL, 8'h00};
            end
            CFG2: begin
                cs     = 1'b1;
                we     = 1'b1;
                addr   = 8'h01;
                dwrite = {8'h00, RNG2_VAL};
            end
`endif
            default: ;
        endcase
    end

    // Health-test history (last_mix, rep_ctr) survives across words; only first restarts it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            p_reg      <= 16'h0000;
            last_mix   <= 16'h0000;
            rep_ctr    <= 4'd0;
            half       <= 1'b0;
            delay_ctr  <= 8'd0;
            first      <= 1'b0;
            data       <= 32'h0000_0000;
            data_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        delay_ctr <= 8'd0;
                        half      <= 1'b0;
                        first     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (enable) delay_ctr <= delay_ctr + 8'd1;
                end
                RD_P: begin
                    if (enable) p_reg <= dread;
                end
                RD_N: begin
                    if (enable) begin
                        last_mix <= mix;
                        if (first) begin
                            rep_ctr <= 4'd0;
                            first   <= 1'b0;
                        end else if (mix == last_mix) begin
                            rep_ctr <= rep_ctr + 4'd1;
                        end else begin
                            rep_ctr <= 4'd0;
                        end
                        if (health_fail) begin
                            error <= 1'b1;
                        end else if (!half) begin
                            data[15:0] <= mix;
                            half       <= 1'b1;
                            delay_ctr  <= 8'd0;
                        end else begin
                            data[31:16] <= mix;
                            half        <= 1'b0;
                            data_valid  <= 1'b1;
                        end
                    end
                end
                VALID: begin
                    if (data_ack) begin
                        data_valid <= 1'b0;
                        delay_ctr  <= 8'd0;
                    end
                end
                ERROR: begin
                    if (!enable) error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_entropy_collector.sv
// Scoreboard bench for entropy_collector: a bus responder serves P/N words from a table,
// a monitor checks every delivered word against the expected-word queue.
module tb_entropy_collector;

    localparam int SAMPLE_DELAY = 8;
    localparam logic [7:0] ADDR_P = 8'h11;
    localparam logic [7:0] ADDR_N = 8'h12;
`ifdef ENTROPY_COLLECTOR_RNG_CFG_EN
    localparam int LAT    = 22;
    localparam int CFG_WR = 2;
`else
    localparam int LAT    = 20;
    localparam int CFG_WR = 0;
`endif
    localparam int LIMIT = 300;

    logic        clk;
    logic        nreset;
    logic        enable;
    logic        cs;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] dwrite;
    logic [15:0] dread;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ack;
    logic        error;

    int assert_count = 0;
    int fail_count   = 0;
    int rd_n_count   = 0;
    int cyc          = 0;
    bit prev_valid   = 1'b0;

    logic [15:0] tbl_p [0:15];
    logic [15:0] tbl_n [0:15];
    logic [31:0] exp_q [$];
    logic [31:0] bus_log [$];
    int          bus_cyc [$];

    entropy_collector dut (
        .clk        (clk),
        .nreset     (nreset),
        .enable     (enable),
        .cs         (cs),
        .we         (we),
        .addr       (addr),
        .dwrite     (dwrite),
        .dread      (dread),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational generator model: the current table pair advances after each N read.
    always_comb begin
        dread = 16'h0000;
        if (cs && !we && rd_n_count < 16) begin
            if (addr == ADDR_P)      dread = tbl_p[rd_n_count];
            else if (addr == ADDR_N) dread = tbl_n[rd_n_count];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (nreset && cs && !we && addr == ADDR_N) rd_n_count <= rd_n_count + 1;
    end

    always @(negedge clk) begin
        if (cs) begin
            bus_log.push_back({7'b0, we, addr, dwrite});
            bus_cyc.push_back(cyc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every rising data_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (data_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", data, 32'hxxxx_xxxx);
            end else begin
                checkOutput("word", data, exp_q.pop_front());
            end
        end
        prev_valid = data_valid;
    end

    task automatic applyStimulus(input bit en, input bit ack);
        @(negedge clk);
        enable   = en;
        data_ack = ack;
    endtask

    task automatic waitValid(output int edges);
        edges = 0;
        while (edges < LIMIT) begin
            @(posedge clk);
            edges++;
            #1;
            if (data_valid) break;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int edges;
        int cnt;
        int bad;
        int n0;
        int log_start;
        int rdn;
        int last_rdn_cyc;
        int err_cyc;
        bit found;
        logic [31:0] exp_bus [0:5];

        tbl_p[0]  = 16'h1234; tbl_n[0]  = 16'h00FF;
        tbl_p[1]  = 16'hA5A5; tbl_n[1]  = 16'h5A5A;
        tbl_p[2]  = 16'h0F0F; tbl_n[2]  = 16'h0101;
        tbl_p[3]  = 16'h8000; tbl_n[3]  = 16'h0001;
        for (int i = 4; i < 8; i++) begin
            tbl_p[i] = 16'hFFFF; tbl_n[i] = 16'h0000;
        end
        tbl_p[8]  = 16'h1111; tbl_n[8]  = 16'h2222;
        tbl_p[9]  = 16'h4444; tbl_n[9]  = 16'h1000;
        tbl_p[10] = 16'h0001; tbl_n[10] = 16'h0003;
        for (int i = 11; i < 16; i++) begin
            tbl_p[i] = 16'h0BAD; tbl_n[i] = 16'h0001;
        end

        nreset   = 1'b0;
        enable   = 1'b0;
        data_ack = 1'b0;
        #1;
        checkOutput("reset_cs", {31'b0, cs}, 32'd0);
        checkOutput("reset_we", {31'b0, we}, 32'd0);
        checkOutput("reset_addr", {24'b0, addr}, 32'd0);
        checkOutput("reset_dwrite", {16'b0, dwrite}, 32'd0);
        checkOutput("reset_data", data, 32'd0);
        checkOutput("reset_valid", {31'b0, data_valid}, 32'd0);
        checkOutput("reset_error", {31'b0, error}, 32'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        $display("[TB] basic word");
        exp_q.push_back(32'hFFFF_12CB);
        log_start = bus_log.size();
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        waitValid(edges);
        checkOutput("latency_basic", edges, LAT);
        checkOutput("bus_count", bus_log.size() - log_start, 4 + CFG_WR);
`ifdef ENTROPY_COLLECTOR_RNG_CFG_EN
        exp_bus[0] = 32'h0100_3300;
        exp_bus[1] = 32'h0101_00CC;
`endif
        exp_bus[CFG_WR + 0] = 32'h0011_0000;
        exp_bus[CFG_WR + 1] = 32'h0012_0000;
        exp_bus[CFG_WR + 2] = 32'h0011_0000;
        exp_bus[CFG_WR + 3] = 32'h0012_0000;
        for (int i = 0; i < 4 + CFG_WR; i++) begin
            if (log_start + i < bus_log.size())
                checkOutput("bus_cycle", bus_log[log_start + i], exp_bus[i]);
        end

        $display("[TB] backpressure");
        exp_q.push_back(32'h8001_0E0E);
        bad = 0;
        n0  = bus_log.size();
        repeat (50) begin
            @(negedge clk);
            if (cs || !data_valid || data !== 32'hFFFF_12CB) bad++;
        end
        checkOutput("backpressure_hold", bad + (bus_log.size() - n0), 0);
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("valid_drop_after_ack", {31'b0, data_valid}, 32'd0);
        data_ack = 1'b0;
        cnt   = 0;
        found = 1'b0;
        while (cnt < LIMIT && !found) begin
            @(negedge clk);
            if (cs && !we && addr == ADDR_P) found = 1'b1;
            else begin
                @(posedge clk);
                cnt++;
            end
        end
        checkOutput("next_read_edges", cnt + 1, SAMPLE_DELAY + 1);
        waitValid(edges);
        checkOutput("second_word_valid", {31'b0, data_valid}, 32'd1);
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("ack_with_disable", {31'b0, data_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] health test");
        exp_q.push_back(32'hFFFF_FFFF);
        log_start = bus_log.size();
        applyStimulus(1'b1, 1'b0);
        waitValid(edges);
        checkOutput("health_first_word", {31'b0, data_valid}, 32'd1);
        applyStimulus(1'b1, 1'b1);
        @(posedge clk);
        #1;
        data_ack = 1'b0;
        cnt = 0;
        while (!error && cnt < LIMIT) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        err_cyc = cyc;
        checkOutput("error_set", {31'b0, error}, 32'd1);
        rdn = 0;
        last_rdn_cyc = -10;
        for (int i = log_start; i < bus_log.size(); i++) begin
            if (bus_log[i] == 32'h0012_0000) begin
                rdn++;
                last_rdn_cyc = bus_cyc[i];
            end
        end
        checkOutput("rd_n_before_error", rdn, 4);
        checkOutput("error_edge", err_cyc, last_rdn_cyc + 1);
        bad = 0;
        n0  = bus_log.size();
        repeat (30) begin
            @(negedge clk);
            if (cs || data_valid || !error) bad++;
        end
        checkOutput("error_quiet", bad + (bus_log.size() - n0), 0);
        applyStimulus(1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("error_clear", {31'b0, error}, 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] enable drop mid-word");
        applyStimulus(1'b1, 1'b0);
        cnt = 0;
        while (rd_n_count < 9 && cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
        end
        enable = 1'b0;
        bad = 0;
        n0  = bus_log.size();
        repeat (20) begin
            @(negedge clk);
            if (cs || data_valid) bad++;
        end
        checkOutput("drop_quiet", bad + (bus_log.size() - n0), 0);
        exp_q.push_back(32'h0002_5444);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        waitValid(edges);
        checkOutput("latency_reenable", edges, LAT);
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] async reset in RD_P");
        applyStimulus(1'b1, 1'b0);
        cnt   = 0;
        found = 1'b0;
        while (cnt < LIMIT && !found) begin
            @(negedge clk);
            cnt++;
            if (cs && !we && addr == ADDR_P) found = 1'b1;
        end
        checkOutput("reached_rd_p", {31'b0, found}, 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        checkOutput("async_cs", {31'b0, cs}, 32'd0);
        checkOutput("async_addr", {24'b0, addr}, 32'd0);
        checkOutput("async_valid", {31'b0, data_valid}, 32'd0);
        checkOutput("async_error", {31'b0, error}, 32'd0);
        checkOutput("async_data", data, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (cs || data_valid) bad++;
        end
        checkOutput("post_reset_idle", bad, 0);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/entropy_collector.md
Name: entropy_collector

Overview:
- Bus initiator that drives the 16-bit cs/we/addr/dwrite/dread register interface of the digital entropy generator.
- Periodically reads the generator's P and N oscillator words and XOR-mixes each pair into a 16-bit sample.
- Runs a repetition health test on the samples.
- Packs two samples into a 32-bit word and hands it to the consumer over a valid/ack handshake.

Parameters:
- SAMPLE_DELAY, 8: idle cycles in WAIT between sample pairs; legal range 1..255.
- REPEAT_MAX, 4: number of consecutive identical samples that trips the health error; legal range 2..15.
- ADDR_P, 8'h11: generator address of the P word.
- ADDR_N, 8'h12: generator address of the N word.
- RNG1_VAL, 8'h33: rng1 configuration value (used only with the optional feature).
- RNG2_VAL, 8'hcc: rng2 configuration value (used only with the optional feature).

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run collection.
- cs  out  1  bus chip select.
- we  out  1  bus write enable.
- addr  out  8  bus address.
- dwrite  out  16  bus write data.
- dread  in  16  bus read data; combinational from the generator in the same cycle.
- data  out  32  collected entropy word.
- data_valid  out  1  data holds a new word.
- data_ack  in  1  consumer accepts data.
- error  out  1  health test failed; sticky.

Behaviour:
- Reset (asynchronous, nreset=0):
  - state=IDLE.
  - cs, we, data_valid, error = 0; addr=0, dwrite=0, data=0.
  - Internal regs p_reg, last_mix, rep_ctr, half, delay_ctr, first = 0.
- Bus outputs:
  - cs/we/addr/dwrite are decoded from the state register only; there is no combinational path from any input to any output.
  - A bus cycle is exactly one clock with cs=1.
  - Read data is sampled from dread on the rising edge that ends a read cycle (cs=1, we=0).
- States: IDLE, WAIT, RD_P, RD_N, VALID, ERROR.
- IDLE:
  - Bus outputs are 0.
  - enable=1 -> WAIT; on entry, delay_ctr=0, half=0, first=1.
- WAIT:
  - Bus outputs are 0; delay_ctr increments each cycle.
  - After SAMPLE_DELAY cycles -> RD_P.
- RD_P:
  - cs=1, we=0, addr=ADDR_P.
  - Edge actions: p_reg<=dread, then -> RD_N.
- RD_N:
  - cs=1, we=0, addr=ADDR_N; mix = p_reg ^ dread.
  - Health test:
    - If first=1: rep_ctr<=0 and first<=0.
    - Else if mix==last_mix: rep_ctr<=rep_ctr+1.
    - Else: rep_ctr<=0.
    - last_mix<=mix.
  - Failure: if mix==last_mix, first=0 and rep_ctr==REPEAT_MAX-2, the test fails: error<=1, the partial word is discarded, -> ERROR.
  - Otherwise, if half=0: data[15:0]<=mix, half<=1, delay_ctr<=0, -> WAIT.
  - Otherwise (half=1): data[31:16]<=mix, half<=0, data_valid<=1, -> VALID.
- VALID:
  - Bus outputs are 0; data and data_valid hold until data_ack=1.
  - On ack, data_valid<=0, then -> WAIT (delay_ctr=0) if enable=1, else -> IDLE.
  - Enable dropping while in VALID does not cancel the handshake.
  - data_ack is ignored when data_valid=0.
- Enable deassert: enable=0 in WAIT/RD_P/RD_N -> IDLE at the next edge, discarding the partial half; data_valid stays 0.
- ERROR:
  - Bus outputs are 0; error=1.
  - Leaves only on enable=0: -> IDLE and error<=0.
- Latency: from the edge sampling enable=1 to data_valid=1 is 2*(SAMPLE_DELAY+2) edges, i.e. 20 at defaults.
- Health-test state (last_mix, rep_ctr) persists across words; the first flag is reset only on the IDLE->WAIT transition.

Optional Feature:
- Macro: ENTROPY_COLLECTOR_RNG_CFG_EN.
- When defined:
  - IDLE with enable=1 goes to CFG1 instead of WAIT.
  - CFG1: cs=1, we=1, addr=8'h00, dwrite={RNG1_VAL,8'h00}, then -> CFG2.
  - CFG2: cs=1, we=1, addr=8'h01, dwrite={8'h00,RNG2_VAL}, then -> WAIT.
  - enable=0 in CFG1/CFG2 -> IDLE.
  - Latency increases by 2 edges (22 at defaults).
- When undefined: we is tied to 0, dwrite is tied to 0, and the CFG states do not exist.

Test Plan:
- Basic word, defaults:
  - Stimulus: bench responder returns P=0x1234, N=0x00FF, then P=0xA5A5, N=0x5A5A.
  - Required: data_valid rises 20 edges after enable is sampled, with data=0xFFFF12CB.
  - Bus trace: addr 0x11 then 0x12 on each sample, cs high for exactly 1 cycle each, we=0 throughout.
- Backpressure:
  - Stimulus: hold data_ack=0 for 50 cycles after data_valid.
  - Required: data stable, cs=0 for all 50 cycles; after ack, data_valid=0 next edge and the next read is issued SAMPLE_DELAY+1 edges later.
- Health fail:
  - Stimulus: responder constant P=0xFFFF, N=0x0000, ack immediately.
  - Required: first word 0xFFFFFFFF is delivered; error=1 at the edge ending the 4th RD_N; no further cs pulses and no second data_valid.
  - Then drop enable: error=0 and state IDLE.
- Enable drop mid-word:
  - Stimulus: deassert enable during the WAIT after the first half.
  - Required: cs stays 0 and no data_valid.
  - Stimulus: re-enable.
  - Required: full 20-edge latency again, with data built from the new pairs only.
- Asynchronous reset during RD_P:
  - Stimulus: assert nreset=0 while in RD_P.
  - Required: cs, data_valid, error, data go to 0 immediately, without a clock edge.
- Macro build (ENTROPY_COLLECTOR_RNG_CFG_EN defined):
  - Required: first two bus cycles are writes: addr 0x00/dwrite 0x3300, then addr 0x01/dwrite 0x00CC; then reads; data_valid latency is 22 edges.
